gray_sequencer: RTL and testbench
=================================

// Module: gray_sequencer
// PURPOSE
//  Binary-to-Gray encoder wrapped around an up/down step counter; the
//  transmit-side counterpart of the Gray decoder path.
//  Generates the WIDTH-bit Gray sequence automatically (prescaled tick) or
//  manually (step pulses), or encodes a loaded binary value.
//  Output gray feeds the Gray decoder / LED display chain; bin_cnt is the
//  round-trip reference for that chain.
// PARAMETERS
//  WIDTH     4           counter / code width in bits (>=2)
//  TICK_DIV  13_500_000  clk cycles per auto step (0.5 s @ 27 MHz); >=2
// PORTS
//  clk      in   1      system clock, all state on rising edge
//  rst      in   1      asynchronous, active-high reset
//  en       in   1      level; 1 = auto-run on prescaler ticks
//  step     in   1      single-cycle pulse (pre-debounced), one manual advance
//  dir      in   1      1 = count up, 0 = count down (sampled on each advance)
//  load     in   1      single-cycle pulse, load bin_in
//  bin_in   in   WIDTH  binary value to encode on load
//  gray     out  WIDTH  registered Gray code of bin_cnt
//  bin_cnt  out  WIDTH  registered binary count
//  valid    out  1      1-cycle pulse: gray/bin_cnt just updated
//  wrap     out  1      1-cycle pulse: count wrapped (max->0 up, 0->max down)
// BEHAVIOUR
//  Reset (async, immediate, any time): bin_cnt=0, gray=0, valid=0, wrap=0,
//   prescaler=0, state=IDLE. First edge after release behaves as normal.
//  FSM: IDLE --en=1--> RUN; RUN --en=0--> IDLE. Transition takes effect on
//   the edge en is sampled; prescaler forced to 0 in IDLE and on RUN->IDLE.
//  Prescaler (RUN only): counts 0..TICK_DIV-1; tick asserted internally in the
//   cycle count==TICK_DIV-1, count returns to 0 next edge. First tick after
//   entering RUN occurs TICK_DIV cycles after the entry edge.
//  Advance event = tick OR step (step honoured in IDLE and RUN).
//  Priority per cycle: load > advance. Tick and step together = ONE advance.
//  Load: bin_cnt<=bin_in, gray<=bin_in^(bin_in>>1), prescaler<=0, valid=1,
//   wrap=0; a coincident tick/step is discarded.
//  Advance: bin_cnt<=bin_cnt+1 (dir=1) or -1 (dir=0), modulo 2^WIDTH;
//   gray<=next^(next>>1) computed from the NEW value, same edge; valid=1.
//  wrap=1 with valid on max->0 (up) or 0->max (down) only.
//  Latency: event sampled on edge N -> gray/bin_cnt/valid/wrap visible after
//   edge N. gray and bin_cnt never disagree in any cycle.
//  No event: outputs hold; valid=0, wrap=0.
//  Successive gray outputs from advances differ in exactly one bit
//   (including wrap); load may change any number of bits.
//  dir change mid-run: affects next advance only; no glitch, no extra step.
// TESTING (bench uses WIDTH=4, TICK_DIV=4)
//  1 Reset then 16 step pulses dir=1 -> gray = 1,3,2,6,7,5,4,C,D,F,E,A,B,9,8,0;
//    wrap=1 only on the 16th (bin_cnt F->0); valid once per step.
//  2 en=1 held 17 cycles from reset release -> 4 advances, valid on cycles
//    4,8,12,16 after entry; en=0 -> no further advance; prescaler restarts.
//  3 load bin_in=9 with step same cycle -> bin_cnt=9, gray=D, wrap=0; no step;
//    then step dir=0 x10 -> reaches 0 then F with wrap=1 on 0->F.
//  4 step coincident with tick in RUN -> single advance (bin_cnt +1 only).
//  5 assert rst mid-run (bin_cnt=7) between edges -> outputs 0 immediately,
//    state IDLE; after release with en=1, first advance TICK_DIV cycles later.
//  6 Round trip: gray into Gray decoder for all 16 codes -> decoder binary ==
//    bin_cnt every cycle; one-bit-change check on every valid.

Source files
------------

// File: rtl/gray_sequencer.sv
// Up/down step counter with registered Gray encoding; auto-runs on a prescaled tick or steps manually.
// Latency: an event sampled on edge N is visible after edge N. There is no backpressure; load beats advance.
module gray_sequencer #(
    parameter int WIDTH    = 4,
    parameter int TICK_DIV = 13_500_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             step,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] bin_in,
    output logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin_cnt,
    output logic             valid,
    output logic             wrap
);

    localparam int              PW         = $clog2(TICK_DIV);
    localparam logic [PW-1:0]   PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [WIDTH-1:0] CNT_MAX   = '1;

    typedef enum logic {IDLE, RUN} state_e;

    state_e           state_q, state_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic [WIDTH-1:0] bin_q, bin_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic             valid_q, valid_d;
    logic             wrap_q, wrap_d;
    logic             tick;
    logic             adv;
    logic [WIDTH-1:0] nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            presc_q <= '0;
            bin_q   <= '0;
            gray_q  <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            bin_q   <= bin_d;
            gray_q  <= gray_d;
            valid_q <= valid_d;
            wrap_q  <= wrap_d;
        end
    end

    // Prescaler only counts while staying in RUN; leaving RUN on this edge suppresses the tick.
    always_comb begin
        state_d = state_q;
        presc_d = '0;
        tick    = 1'b0;
        case (state_q)
            IDLE: begin
                if (en) state_d = RUN;
            end
            RUN: begin
                if (!en) begin
                    state_d = IDLE;
                end else begin
                    tick    = (presc_q == PRESC_LAST);
                    presc_d = (tick || load) ? '0 : presc_q + PW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        adv     = tick | step;
        nxt     = dir ? bin_q + WIDTH'(1) : bin_q - WIDTH'(1);
        bin_d   = bin_q;
        gray_d  = gray_q;
        valid_d = 1'b0;
        wrap_d  = 1'b0;
        if (load) begin
            bin_d   = bin_in;
            gray_d  = bin_in ^ (bin_in >> 1);
            valid_d = 1'b1;
        end else if (adv) begin
            bin_d   = nxt;
            gray_d  = nxt ^ (nxt >> 1);
            valid_d = 1'b1;
            wrap_d  = dir ? (bin_q == CNT_MAX) : (bin_q == '0);
        end
    end

    assign gray    = gray_q;
    assign bin_cnt = bin_q;
    assign valid   = valid_q;
    assign wrap    = wrap_q;

endmodule

// File: tb/tb_gray_sequencer.sv
// Bench for gray_sequencer: directed scenarios plus random stimulus against a behavioural model.
module tb_gray_sequencer;

    localparam int W  = 4;
    localparam int TD = 4;
    localparam int MAXV = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b0, step = 1'b0, dir = 1'b1, load = 1'b0;
    logic [W-1:0] bin_in = '0;
    logic [W-1:0] gray, bin_cnt;
    logic         valid, wrap;

    int total = 0;
    int bad   = 0;

    gray_sequencer #(.WIDTH(W), .TICK_DIV(TD)) dut (
        .clk(clk), .rst(rst), .en(en), .step(step), .dir(dir), .load(load),
        .bin_in(bin_in), .gray(gray), .bin_cnt(bin_cnt), .valid(valid), .wrap(wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int to_gray(input int b);
        return b ^ (b >> 1);
    endfunction

    // Gray decode by accumulating all right-shifts (prefix XOR from the MSB down).
    function automatic int from_gray(input int g);
        int b = g;
        int s = g >> 1;
        while (s != 0) begin
            b = b ^ s;
            s = s >> 1;
        end
        return b;
    endfunction

    // Behavioural model: running flag, cycles since last restart, count value.
    int m_bin, m_phase;
    bit m_run, m_valid, m_wrap, m_load;
    int n_bin, n_phase;
    bit n_valid, n_wrap, n_load, n_tick;

    always_comb begin
        n_tick  = m_run && en && (m_phase == TD - 1);
        n_bin   = m_bin;
        n_valid = 1'b0;
        n_wrap  = 1'b0;
        n_load  = 1'b0;
        if (load) begin
            n_bin   = int'(bin_in);
            n_valid = 1'b1;
            n_load  = 1'b1;
        end else if (n_tick || step) begin
            n_valid = 1'b1;
            if (dir) begin
                n_wrap = (m_bin == MAXV);
                n_bin  = (m_bin + 1) % (MAXV + 1);
            end else begin
                n_wrap = (m_bin == 0);
                n_bin  = (m_bin + MAXV) % (MAXV + 1);
            end
        end
        if (!(m_run && en) || load || n_tick) n_phase = 0;
        else n_phase = m_phase + 1;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_bin <= 0; m_phase <= 0; m_run <= 1'b0;
            m_valid <= 1'b0; m_wrap <= 1'b0; m_load <= 1'b0;
        end else begin
            m_bin <= n_bin; m_phase <= n_phase; m_run <= en;
            m_valid <= n_valid; m_wrap <= n_wrap; m_load <= n_load;
        end
    end

    // Per-cycle comparison against the model, round-trip decode and one-bit-change rule.
    int prev_g = 0;
    always @(negedge clk) begin
        if (rst) begin
            prev_g <= 0;
        end else begin
            check("model_bin",  int'(bin_cnt), m_bin);
            check("model_gray", int'(gray), to_gray(m_bin));
            check("model_valid", int'(valid), int'(m_valid));
            check("model_wrap",  int'(wrap), int'(m_wrap));
            check("roundtrip", from_gray(int'(gray)), int'(bin_cnt));
            if (valid && !m_load)
                check("onebit", $countones(int'(gray) ^ prev_g), 1);
            prev_g <= int'(gray);
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; en = 1'b0; step = 1'b0; load = 1'b0; dir = 1'b1;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic step_once(input logic d);
        step = 1'b1; dir = d;
        @(negedge clk);
        step = 1'b0;
    endtask

    int exp_seq [16] = '{1, 3, 2, 6, 7, 5, 4, 'hC, 'hD, 'hF, 'hE, 'hA, 'hB, 9, 8, 0};
    int vmask;
    int idx;
    bit seen;

    initial begin
        // 1: reset state and 16 upward steps
        @(negedge clk);
        @(negedge clk);
        check("rst_gray", int'(gray), 0);
        check("rst_bin", int'(bin_cnt), 0);
        check("rst_valid", int'(valid), 0);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            step_once(1'b1);
            check("seq_gray", int'(gray), exp_seq[i]);
            check("seq_valid", int'(valid), 1);
            check("seq_wrap", int'(wrap), (i == 15) ? 1 : 0);
        end
        @(negedge clk);
        check("idle_valid", int'(valid), 0);

        // 2: auto-run from reset release for 17 cycles
        do_reset();
        rst = 1'b0; en = 1'b1;
        vmask = 0;
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            if (valid) vmask = vmask | (1 << i);
        end
        check("run_valid_mask", vmask, 'h11110);
        check("run_bin", int'(bin_cnt), 4);
        en = 1'b0;
        vmask = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (valid) vmask = vmask | (1 << i);
        end
        check("stop_no_valid", vmask, 0);
        check("stop_bin", int'(bin_cnt), 4);

        // 3: load beats step, then count down through wrap
        bin_in = 4'd9; load = 1'b1; step = 1'b1; dir = 1'b1;
        @(negedge clk);
        load = 1'b0; step = 1'b0;
        check("load_bin", int'(bin_cnt), 9);
        check("load_gray", int'(gray), 'hD);
        check("load_wrap", int'(wrap), 0);
        for (int i = 0; i < 10; i++) begin
            step_once(1'b0);
            check("down_wrap", int'(wrap), (i == 9) ? 1 : 0);
        end
        check("down_bin", int'(bin_cnt), 'hF);

        // 4: step coincident with tick counts once
        do_reset();
        rst = 1'b0; en = 1'b1;
        for (int i = 0; i < 4; i++) @(negedge clk);
        step = 1'b1; dir = 1'b1;
        @(negedge clk);
        step = 1'b0;
        check("coinc_bin", int'(bin_cnt), 1);
        check("coinc_valid", int'(valid), 1);

        // 5: async reset mid-run at bin_cnt=7
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (bin_cnt == 4'd7) seen = 1'b1;
        end
        check("reach7_timeout", int'(seen), 1);
        #2 rst = 1'b1;
        #1;
        check("async_bin", int'(bin_cnt), 0);
        check("async_gray", int'(gray), 0);
        check("async_valid", int'(valid), 0);
        @(negedge clk);
        rst = 1'b0;
        idx = -1;
        for (int i = 0; i < 20 && idx < 0; i++) begin
            @(negedge clk);
            if (valid) idx = i;
        end
        check("restart_latency", idx, TD);

        // 6: random stimulus, checked every cycle against the model
        for (int i = 0; i < 1500; i++) begin
            en     = ($urandom_range(0, 3) != 0);
            step   = ($urandom_range(0, 4) == 0);
            dir    = 1'($urandom_range(0, 1));
            load   = ($urandom_range(0, 15) == 0);
            bin_in = W'($urandom_range(0, MAXV));
            @(negedge clk);
        end
        en = 1'b0; step = 1'b0; load = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 16; i++) step_once(1'b1);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
